// File: rtl/decoded_msg_reader_if.sv
// RAM read port plus valid/ready byte stream of the decoded-message reader.
// The reader is the master: it drives the RAM address/enables and the byte stream.
interface decoded_msg_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] ram_address;
  logic              ram_rden;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  modport master (
    output ram_address, ram_rden, ram_wren, out_valid, out_data, out_last,
    input  ram_q, out_ready
  );

  modport slave (
    input  ram_address, ram_rden, ram_wren, out_valid, out_data, out_last,
    output ram_q, out_ready
  );
endinterface

// File: rtl/decoded_msg_reader.sv
// Drains the decoded-message RAM one byte at a time after a successful key search
// and presents each byte on a valid/ready stream for the LCD/UART formatter.
module decoded_msg_reader #(
  parameter int MSG_LEN     = 32,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 8,
  parameter int RD_LATENCY  = 1,
  parameter bit STOP_ON_NUL = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  decoded_msg_reader_if.master bus,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     byte_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_PRESENT,
    S_FINISH
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(MSG_LEN - 1);
  localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(MSG_LEN);
  localparam logic [1:0]        WAIT_LAST = 2'(RD_LATENCY - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [1:0]          wait_q, wait_d;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wait_d  = wait_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          data_d  = bus.ram_q;
          state_d = S_CHECK;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      S_CHECK: begin
        // A NUL terminator ends the drain silently: it is never presented.
        if (STOP_ON_NUL && (data_q == '0)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          last_d  = 1'b0;
          state_d = S_FINISH;
        end else begin
          valid_d = 1'b1;
          last_d  = (idx_q == LAST_IDX);
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          if (count_q != COUNT_MAX) count_d = count_q + 1'b1;
          if (last_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            last_d  = 1'b0;
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a same-cycle handshake or start.
    if (abort) begin
      if (state_q != S_IDLE) begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        count_d = count_q;
        idx_d   = idx_q;
      end else begin
        state_d = S_IDLE;
        idx_d   = idx_q;
        count_d = count_q;
        busy_d  = busy_q;
      end
    end
  end

  assign bus.ram_address = idx_q;
  assign bus.ram_rden    = (state_q == S_ISSUE);
  assign bus.ram_wren    = 1'b0;
  assign bus.out_valid   = valid_q;
  assign bus.out_data    = data_q;
  assign bus.out_last    = last_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign byte_count      = count_q;

endmodule

// File: tb/tb_decoded_msg_reader.sv
// Bench for decoded_msg_reader: three instances (latency 1, latency 2, stop-on-NUL)
// driven with random back-pressure and checked against a queue-based message model.
module tb_decoded_msg_reader;

  logic clk;
  logic reset_n;
  logic out_ready;
  logic [2:0] start_s, abort_s;
  logic [2:0] v_s, l_s, busy_s, done_s, rden_s, wren_s;
  logic [2:0][7:0] d_s;
  logic [2:0][4:0] a_s;
  logic [2:0][5:0] bc_s;
  logic [7:0] mem [32];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int LAT = (g == 1) ? 2 : 1;
    localparam bit NUL = (g == 2);
    logic [7:0] stage1, stage2;

    decoded_msg_reader_if #(.ADDR_W(5), .DATA_W(8)) bus ();

    // Behavioural RAM: stage1 loads on rden, stage2 delays it one more cycle.
    always @(posedge clk) begin
      if (bus.ram_rden) stage1 <= mem[bus.ram_address];
      stage2 <= stage1;
    end

    assign bus.ram_q     = (LAT == 2) ? stage2 : stage1;
    assign bus.out_ready = out_ready;

    decoded_msg_reader #(
      .MSG_LEN(32), .ADDR_W(5), .DATA_W(8), .RD_LATENCY(LAT), .STOP_ON_NUL(NUL)
    ) dut (
      .clk(clk), .reset_n(reset_n), .start(start_s[g]), .abort(abort_s[g]),
      .bus(bus.master), .busy(busy_s[g]), .done(done_s[g]), .byte_count(bc_s[g])
    );

    assign v_s[g]    = bus.out_valid;
    assign l_s[g]    = bus.out_last;
    assign d_s[g]    = bus.out_data;
    assign a_s[g]    = bus.ram_address;
    assign rden_s[g] = bus.ram_rden;
    assign wren_s[g] = bus.ram_wren;
  end

  task automatic check(input string tag, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int lat_of(input int g);
    return (g == 1) ? 2 : 1;
  endfunction

  function automatic bit nul_of(input int g);
    return (g == 2);
  endfunction

  task automatic check_reset_vals(input int g);
    check("rst_busy",  busy_s[g], 0);
    check("rst_valid", v_s[g],    0);
    check("rst_data",  d_s[g],    0);
    check("rst_last",  l_s[g],    0);
    check("rst_done",  done_s[g], 0);
    check("rst_count", bc_s[g],   0);
    check("rst_rden",  rden_s[g], 0);
    check("rst_addr",  a_s[g],    0);
    check("rst_wren",  wren_s[g], 0);
  endtask

  task automatic load_hello();
    string s = "Hello, world!";
    for (int i = 0; i < 32; i++) mem[i] = (i < s.len()) ? s[i] : 8'h2E;
  endtask

  // mode 0: complete drain; 1: abort on byte ev_byte; 2: reset on byte ev_byte (plus stray start)
  task automatic run_drain(input int g, input bit rand_ready, input int mode, input int ev_byte);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit         got_l[$];
    int  first_k = -1, rise_k = -1, hs_k = -1, done_k = -1, done_cnt = 0;
    int  max_addr = -1, bc_done = -1, lat = lat_of(g);
    bit  prev_v = 0, prev_stall = 0, prev_l = 0, finished = 0, stray = 0, wren_seen = 0;
    logic [7:0] prev_d = 8'h00;

    for (int i = 0; i < 32; i++) begin
      if (nul_of(g) && mem[i] == 8'h00) break;
      exp_q.push_back(mem[i]);
    end

    @(negedge clk);
    start_s[g] = 1'b1;
    out_ready  = 1'b1;
    for (int k = 0; k < 2000 && !finished; k++) begin
      logic v, l;
      logic [7:0] d;
      @(negedge clk);
      start_s[g] = 1'b0;
      abort_s[g] = 1'b0;
      v = v_s[g];
      l = l_s[g];
      d = d_s[g];
      if (rden_s[g] && int'(a_s[g]) > max_addr) max_addr = int'(a_s[g]);
      if (wren_s[g]) wren_seen = 1;
      if (prev_stall) begin
        check("hold_valid", v, 1);
        check("hold_data", d, prev_d);
        check("hold_last", l, prev_l);
      end
      if (v && !prev_v) begin
        if (first_k < 0) first_k = k;
        else if (!rand_ready) check("byte_period", k - rise_k, lat + 3);
        rise_k = k;
      end
      if (done_s[g]) begin
        done_cnt++;
        done_k   = k;
        bc_done  = int'(bc_s[g]);
        finished = 1;
        check("busy_at_done", busy_s[g], 0);
      end
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v && mode == 2 && got_q.size() == 3 && !stray) begin
        start_s[g] = 1'b1;
        stray = 1;
      end
      if (v && mode == 1 && got_q.size() == ev_byte) begin
        out_ready  = 1'b1;
        abort_s[g] = 1'b1;
        break;
      end
      if (v && mode == 2 && got_q.size() == ev_byte) begin
        reset_n = 1'b0;
        break;
      end
      if (v && out_ready) begin
        got_q.push_back(d);
        got_l.push_back(l);
        hs_k = k;
      end
      prev_v = v;
      prev_stall = v && !out_ready;
      prev_d = d;
      prev_l = l;
    end

    if (mode == 0) begin
      check("drain_finished", finished, 1);
      if (exp_q.size() > 0) check("first_valid_lat", first_k, lat + 2);
      check("n_bytes", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        check("byte_data", got_q[i], exp_q[i]);
        check("byte_last", got_l[i], (i == 31));
      end
      check("byte_count", bc_done, exp_q.size());
      if (exp_q.size() == 32) check("done_after_hs", done_k, hs_k + 1);
      else check("done_after_nul", done_k, hs_k + lat + 3);
      check("max_rd_addr", max_addr, (exp_q.size() == 32) ? 31 : exp_q.size());
      check("wren_zero", wren_seen, 0);
      repeat (4) begin
        @(negedge clk);
        if (done_s[g]) done_cnt++;
      end
      check("done_once", done_cnt, 1);
      check("count_hold", bc_s[g], exp_q.size());
      check("idle_busy", busy_s[g], 0);
    end else if (mode == 1) begin
      @(negedge clk);
      abort_s[g] = 1'b0;
      check("abort_busy", busy_s[g], 0);
      check("abort_valid", v_s[g], 0);
      check("abort_last", l_s[g], 0);
      check("abort_done", done_s[g], 0);
      check("abort_count", bc_s[g], ev_byte);
      repeat (4) begin
        @(negedge clk);
        if (done_s[g]) done_cnt++;
      end
      check("abort_no_done", done_cnt, 0);
    end else begin
      #1;
      check_reset_vals(g);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) begin
        @(negedge clk);
        if (done_s[g] || busy_s[g]) done_cnt++;
      end
      check("reset_quiet", done_cnt, 0);
      check("reset_prefix_len", got_q.size(), ev_byte);
      for (int i = 0; i < got_q.size(); i++) check("reset_prefix", got_q[i], exp_q[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    out_ready = 1'b0;
    start_s   = '0;
    abort_s   = '0;
    load_hello();
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) check_reset_vals(g);
    reset_n = 1'b1;
    @(negedge clk);

    run_drain(0, 1'b0, 0, 0);
    run_drain(0, 1'b1, 0, 0);
    run_drain(1, 1'b0, 0, 0);
    run_drain(1, 1'b1, 0, 0);

    // start and abort together while idle: abort wins
    @(negedge clk);
    start_s[0] = 1'b1;
    abort_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    abort_s[0] = 1'b0;
    check("start_abort_busy", busy_s[0], 0);
    @(negedge clk);
    check("start_abort_rden", rden_s[0], 0);
    check("start_abort_busy2", busy_s[0], 0);

    run_drain(0, 1'b0, 1, 5);
    run_drain(0, 1'b0, 0, 0);
    run_drain(0, 1'b1, 2, 10);

    for (int i = 0; i < 32; i++) mem[i] = 8'h2E;
    mem[0] = 8'h61;
    mem[1] = 8'h62;
    mem[2] = 8'h63;
    mem[3] = 8'h00;
    run_drain(2, 1'b0, 0, 0);
    run_drain(2, 1'b1, 0, 0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] = 8'($urandom_range(1, 255));
        if ($urandom_range(0, 9) == 0) mem[i] = 8'h00;
      end
      for (int g = 0; g < 3; g++) run_drain(g, 1'b1, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decoded_msg_reader.md
Name: decoded_msg_reader

Overview:
- Drains the 32-byte decoded-message RAM after a key-search core reports success, and streams the bytes out over a valid/ready byte interface.
- Downstream consumers are an LCD/UART formatter.
- Read-side counterpart of the decrypt FSM that writes the RAM.
- Drives the RAM read port itself: address, read enable, and write enable held at 0. The core-level mux grants this block the port while busy=1.

Parameters:
- MSG_LEN, 32, number of bytes in the message, 1..2^ADDR_W.
- ADDR_W, 5, RAM address width.
- DATA_W, 8, RAM data width.
- RD_LATENCY, 1, RAM read latency in clk cycles from address/rden to valid ram_q; legal values 1 or 2.
- STOP_ON_NUL, 0, when 1 a 0x00 byte terminates the message early and is not emitted.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a drain (tied to core success)
- abort  in  1  synchronous abandon of the current drain
- ram_address  out  ADDR_W  RAM read address
- ram_rden  out  1  RAM read enable
- ram_wren  out  1  constant 0
- ram_q  in  DATA_W  RAM read data
- busy  out  1  high from accepted start until return to IDLE
- out_valid  out  1  out_data holds a valid byte
- out_data  out  DATA_W  message byte
- out_last  out  1  qualifies the final byte (with out_valid)
- out_ready  in  1  consumer accepts the byte when high with out_valid
- done  out  1  one-cycle pulse on completion (not on abort)
- byte_count  out  ADDR_W+1  bytes handed off so far in the current drain

Behaviour:
- Reset (async assert, sync release): state=IDLE. ram_address=0, ram_rden=0, ram_wren=0, busy=0, out_valid=0, out_data=0, out_last=0, done=0, byte_count=0, idx=0.
- IDLE:
  - start=1 → idx=0, byte_count=0, busy=1, go ISSUE.
  - start while not IDLE is ignored.
- ISSUE (1 cycle): ram_address=idx, ram_rden=1, go WAIT.
- WAIT (RD_LATENCY cycles): ram_rden=0, ram_address holds idx. On the last WAIT cycle's edge, capture ram_q into out_data and go CHECK.
- CHECK (1 cycle, no outputs visible):
  - STOP_ON_NUL=1 and out_data==0 → go FINISH; the byte is not presented.
  - Otherwise out_valid=1, out_last=(idx==MSG_LEN-1), go PRESENT.
- PRESENT:
  - Hold out_valid, out_data and out_last stable until out_ready=1.
  - On handshake: out_valid=0, byte_count+=1.
  - If out_last → FINISH; else idx+=1 → ISSUE.
- FINISH (1 cycle): done=1, busy=0, out_last=0, go IDLE.
- Latency: first out_valid rises RD_LATENCY+2 cycles after the cycle in which start is sampled. Minimum per-byte period is RD_LATENCY+3 cycles with out_ready held high.
- idx never wraps: MSG_LEN-1 is terminal. byte_count saturates at MSG_LEN and holds its final value in IDLE until the next start.
- abort=1 in any non-IDLE state: next cycle state=IDLE, out_valid=0, out_last=0, ram_rden=0, busy=0, no done pulse. abort has priority over an out_ready handshake in the same cycle, so the byte is not counted. abort in IDLE has no effect.
- start and abort in the same cycle from IDLE: abort wins, stay IDLE.
- reset_n low mid-drain: immediate return to reset values; no done pulse.
- out_data retains the last byte after handshake; only out_valid qualifies it.

Test Plan:
- RAM preloaded with "Hello, world!" followed by 19×0x2E, RD_LATENCY=1, out_ready=1, start pulse:
  - 32 bytes out in address order 0..31, out_last only on byte 31 (0x2E).
  - done pulses once, 1 cycle after the final handshake; byte_count=32.
  - First out_valid exactly 3 cycles after start; 4-cycle byte period.
- Same data, out_ready toggled 1-0-0-1 pseudo-randomly:
  - out_data/out_last never change while out_valid=1 and out_ready=0.
  - All 32 bytes delivered with no duplicates or drops.
- STOP_ON_NUL=1, RAM = "abc",0x00,… :
  - Exactly 0x61,0x62,0x63 emitted, none with out_last.
  - done pulses after byte 0x63; byte_count=3; no read past address 3.
- abort asserted in PRESENT of byte 5 with out_ready=1 the same cycle:
  - Next cycle busy=0, out_valid=0, no done, byte_count=5.
  - A following start restarts at address 0.
- RD_LATENCY=2:
  - ram_q sampled 2 cycles after ram_rden.
  - First out_valid 4 cycles after start; full 32-byte data matches.
- reset_n pulsed low for 1 cycle at byte 10, plus a start pulse issued while busy:
  - Mid-drain start is ignored.
  - After reset, all outputs at reset values, no done pulse.
